// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial transmitter.
// Holds the FSM state encoding, the default clock/line rates and the helper
// that derives clocks-per-bit from them.
package serial_tx_pkg;

  localparam int unsigned DefaultClkHz = 32'd50_000_000;
  localparam int unsigned DefaultBaud  = 32'd115_200;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StStart = 2'b01,
    StData  = 2'b10,
    StStop  = 2'b11
  } tx_state_e;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned calc_divisor(input int unsigned clk_hz,
                                               input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/serial_baud_gen.sv
// Baud-rate tick generator.
// Ports:
//   clk_50  - clock
//   reset_n - asynchronous active-low reset
//   enable  - count while high; low holds the counter at 0
//   tick    - one-cycle pulse in the last clock of each DIVISOR-clock bit period
module serial_baud_gen #(
  parameter int unsigned DIVISOR = 434
) (
  input  logic clk_50,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CntW = $clog2(DIVISOR);
  localparam logic [CntW-1:0] CntMax = CntW'(DIVISOR - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick = enable && (cnt_q == CntMax);
    if (!enable || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// 8N1 serial transmitter, LSB first, idle-high line.
// Ports:
//   clk_50    - clock
//   reset_n   - asynchronous active-low reset
//   data      - byte to send, sampled only when a frame is accepted
//   dataReady - level request; a frame is accepted on any edge seen in idle
//   busy      - high from acceptance until the end of the stop bit
//   tx        - registered serial line output
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ  = DefaultClkHz,
  parameter int unsigned BAUD    = DefaultBaud,
  parameter int unsigned DIVISOR = calc_divisor(CLK_HZ, BAUD)
) (
  input  logic       clk_50,
  input  logic       reset_n,
  input  logic [7:0] data,
  input  logic       dataReady,
  output logic       busy,
  output logic       tx
);

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       bit_tick;

  serial_baud_gen #(
    .DIVISOR(DIVISOR)
  ) u_baud_gen (
    .clk_50 (clk_50),
    .reset_n(reset_n),
    .enable (state_q != StIdle),
    .tick   (bit_tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    busy_d  = busy_q;

    unique case (state_q)
      StIdle: begin
        if (dataReady) begin
          shift_d = data;
          idx_d   = '0;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_tick) begin
          tx_d    = shift_q[0];
          idx_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (bit_tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            idx_d = idx_q + 3'd1;
            // Next bit is the one that becomes shift[0] after this shift.
            tx_d  = shift_q[1];
          end
        end
      end
      StStop: begin
        if (bit_tick) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
module tb_serial_tx;

  localparam int unsigned Div = 4;
  localparam int unsigned FrameClks = 10 * Div;

  logic       clk_50;
  logic       reset_n;
  logic [7:0] data;
  logic       dataReady;
  logic       busy;
  logic       tx;

  int checks = 0;
  int errors = 0;

  serial_tx #(
    .CLK_HZ (400),
    .BAUD   (100),
    .DIVISOR(Div)
  ) dut (
    .clk_50   (clk_50),
    .reset_n  (reset_n),
    .data     (data),
    .dataReady(dataReady),
    .busy     (busy),
    .tx       (tx)
  );

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  task automatic tick();
    @(negedge clk_50);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a frame is the 10-symbol sequence start(0), d[0..7], stop(1), each symbol
  // held Div clocks, with busy high for all of it. Call at the negedge right after acceptance.
  // mode 0: leave data alone, 1: random data each clock, 2: data forced to FF.
  // dataReady is dropped from clock index 'hold' onward (hold >= FrameClks keeps it high).
  task automatic run_frame(input string tag, input logic [7:0] d, input int hold,
                           input int mode);
    logic [9:0] bits;
    bits = {1'b1, d, 1'b0};
    for (int i = 0; i < int'(FrameClks); i++) begin
      chk({tag, "_tx"}, 32'(tx), 32'(bits[i / int'(Div)]));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (i >= hold) dataReady = 1'b0;
      if (mode == 1) data = 8'($urandom);
      else if (mode == 2) data = 8'hFF;
      tick();
    end
    chk({tag, "_end_busy"}, 32'(busy), 32'd0);
    chk({tag, "_end_tx"}, 32'(tx), 32'd1);
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_tx"}, 32'(tx), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      tick();
    end
  endtask

  initial begin
    logic [7:0] b;
    reset_n   = 1'b0;
    dataReady = 1'b0;
    data      = 8'h00;
    tick();
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    tick();
    reset_n = 1'b1;
    check_idle("idle_after_reset", 5);

    // "Q": dataReady held until busy is seen.
    data = 8'h51;
    dataReady = 1'b1;
    tick();
    run_frame("q51", 8'h51, 0, 0);
    check_idle("q51_idle", 3);

    // Continuous request: two frames, one idle-high clock between them.
    data = 8'hA5;
    dataReady = 1'b1;
    tick();
    run_frame("a5_first", 8'hA5, FrameClks, 0);
    tick();
    run_frame("a5_second", 8'hA5, 0, 0);
    check_idle("a5_idle", 3);

    // Data changes mid-frame are ignored.
    data = 8'h00;
    dataReady = 1'b1;
    tick();
    run_frame("mid_change", 8'h00, 0, 2);
    check_idle("mid_change_idle", 2);

    // One-clock request pulse still yields a whole frame.
    data = 8'h00;
    dataReady = 1'b1;
    tick();
    dataReady = 1'b0;
    run_frame("pulse", 8'h00, 0, 0);
    check_idle("pulse_idle", 10);

    // Randomized frames with random request hold, random mid-frame data and random gaps.
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      data = b;
      dataReady = 1'b1;
      tick();
      run_frame("rand", b, int'($urandom_range(0, 39)), 1);
      check_idle("rand_gap", int'($urandom_range(1, 5)));
    end

    // Reset during data bit 3 aborts the frame at once.
    data = 8'h00;
    dataReady = 1'b1;
    tick();
    dataReady = 1'b0;
    repeat (4 * Div + 1) tick();
    chk("pre_abort_busy", 32'(busy), 32'd1);
    chk("pre_abort_tx", 32'(tx), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    tick();
    reset_n = 1'b1;
    check_idle("post_abort", 100);

    // Request presented together with reset release.
    reset_n = 1'b0;
    tick();
    b = 8'($urandom);
    data = b;
    dataReady = 1'b1;
    reset_n = 1'b1;
    tick();
    run_frame("rel_accept", b, 0, 0);
    check_idle("final_idle", 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter CLK_HZ, default 50000000: input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200: line rate in bit/s.
REQ-003 Parameter DIVISOR, default CLK_HZ/BAUD rounded to nearest (434): clocks per bit, minimum 2.
REQ-004 clk_50  input  1: single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  input  1: asynchronous, active-low reset.
REQ-006 data  input  8: byte to transmit, sampled only at acceptance.
REQ-007 dataReady  input  1: level request from upstream; a byte is pending while high.
REQ-008 busy  output  1: high from acceptance until the end of the stop bit.
REQ-009 tx  output  1: serial line, 8N1, LSB first, idle high, driven from a register.

Function
REQ-010 States SHALL be IDLE, START, DATA, STOP.
REQ-011 Acceptance occurs on an edge where state is IDLE and dataReady is 1; on that edge data SHALL be latched into an 8-bit shift register, busy SHALL go to 1, tx SHALL go to 0, and state SHALL go to START.
REQ-012 In IDLE with dataReady 0, tx SHALL stay 1, busy SHALL stay 0, and the baud counter SHALL hold at 0.
REQ-013 Each of START, DATA (per bit), and STOP SHALL last exactly DIVISOR clocks, timed by a baud counter that counts from 0 to DIVISOR-1 and wraps to 0 with a one-cycle bit tick.
REQ-014 On the START tick, tx SHALL take shift[0] and state SHALL go to DATA with a bit index of 0.
REQ-015 On each DATA tick, the shift register SHALL shift right by one and the bit index SHALL increment.
REQ-016 On the DATA tick with bit index 7, tx SHALL go to 1 and state SHALL go to STOP.
REQ-017 On the STOP tick, state SHALL go to IDLE and busy SHALL go to 0, giving a frame of 10*DIVISOR clocks from acceptance to busy falling.
REQ-018 Changes on data or dataReady while busy is 1 SHALL NOT affect the frame in progress.
REQ-019 If dataReady is still 1 in the IDLE cycle after busy falls, a new frame SHALL be accepted on that edge.
  - Back-to-back frames are therefore separated by exactly one idle-high clock.
  - Upstream SHALL deassert dataReady after it observes busy to avoid a repeat send.
REQ-020 The baud counter SHALL be $clog2(DIVISOR) bits wide; the bit index SHALL be 3 bits.
  - No counter may overflow or reach DIVISOR.

Reset
REQ-021 While reset_n is 0, the block SHALL immediately, without a clock, force state=IDLE, tx=1, busy=0, baud counter=0, bit index=0, and shift register=0.
REQ-022 A reset mid-frame SHALL abort the frame: tx returns high at once, and no partial bits resume after release.
REQ-023 After reset_n rises, the first acceptance is possible on the first clock edge at which dataReady is 1.

Structure
REQ-024 A shared package SHALL hold:
  - the state encoding constants (2 bits);
  - the default CLK_HZ and BAUD values;
  - the DIVISOR rounding function.
REQ-025 The baud counter/tick SHALL be a sub-module serial_baud_gen with these ports:
  - clk_50, reset_n;
  - enable (low = hold at 0);
  - tick (one-cycle pulse).
REQ-026 The FSM, shift register, and bit index SHALL reside in serial_tx itself.

Verification (bench uses DIVISOR=4)
REQ-027 Send 8'h51 ("Q"), with dataReady held high until busy is seen:
  - tx SHALL read 0,1,0,0,0,1,0,1,0,1, each level held 4 clocks;
  - busy SHALL be high for exactly 40 clocks.
REQ-028 Hold dataReady high continuously with data=8'hA5: two frames SHALL be sent with exactly 1 idle-high clock between the 40-clock frames.
REQ-029 Change data from 8'h00 to 8'hFF mid-frame: the serialized bits SHALL still equal 8'h00.
REQ-030 Assert reset_n=0 during bit 3 of a frame:
  - tx=1 and busy=0 SHALL hold within the same cycle;
  - after release, with dataReady=0, tx SHALL stay 1 for 100 clocks.
REQ-031 Pulse dataReady for one clock with data=8'h00 while IDLE: one full frame SHALL be sent (start, 8 zeros, stop), and then the block SHALL be idle.
REQ-032 Assert dataReady together with reset release: acceptance SHALL occur on the first edge after reset_n rises.
